parking_exit_gate: RTL and testbench

PARKING_EXIT_GATE -- requirements
Module: parking_exit_gate

---
 rtl/parking_pkg.sv | 26 ++
 rtl/parking_occupancy_counter.sv | 35 +++
 rtl/parking_exit_gate.sv | 168 ++++++++++++++++
 tb/tb_parking_exit_gate.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state encoding, lamp/display codes and exit code for the exit gate
package parking_pkg;

  typedef logic [1:0] gate_state_t;

  localparam gate_state_t ST_IDLE     = 2'd0;
  localparam gate_state_t ST_WAIT_PAY = 2'd1;
  localparam gate_state_t ST_PAY_BAD  = 2'd2;
  localparam gate_state_t ST_OPEN     = 2'd3;

  localparam logic [6:0] HEX_BLANK  = 7'h7F;
  localparam logic [6:0] HEX_WAIT_1 = 7'h06;
  localparam logic [6:0] HEX_WAIT_2 = 7'h2B;
  localparam logic [6:0] HEX_BAD_1  = 7'h06;
  localparam logic [6:0] HEX_BAD_2  = 7'h06;
  localparam logic [6:0] HEX_OPEN_1 = 7'h02;
  localparam logic [6:0] HEX_OPEN_2 = 7'h40;

  localparam logic [1:0] EXIT_CODE_1 = 2'b10;
  localparam logic [1:0] EXIT_CODE_2 = 2'b01;

  function automatic logic code_matches(input logic [1:0] d1, input logic [1:0] d2);
    return (d1 == EXIT_CODE_1) && (d2 == EXIT_CODE_2);
  endfunction

endpackage

// File: rtl/parking_occupancy_counter.sv
// rtl/parking_occupancy_counter.sv - saturating car counter; simultaneous inc/dec cancel out
module parking_occupancy_counter #(
  parameter int CAPACITY = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] count,
  output logic       full
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q != 8'(CAPACITY)) begin
      count_d = count_q + 8'd1;
    end else if (dec && !inc && count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == 8'(CAPACITY));

endmodule

// File: rtl/parking_exit_gate.sv
// rtl/parking_exit_gate.sv - pay-to-exit barrier controller; EXIT_TIMEOUT_EN enables abandon timeout
module parking_exit_gate
  import parking_pkg::*;
#(
  parameter int CAPACITY       = 15,
  parameter int PAY_WAIT       = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_entered,
  input  logic       sensor_exit_approach,
  input  logic       sensor_exit_clear,
  input  logic [1:0] pay_1,
  input  logic [1:0] pay_2,
  output logic       gate_open,
  output logic       car_exited,
  output logic       green_led,
  output logic       red_led,
  output logic [6:0] hex_1,
  output logic [6:0] hex_2,
  output logic [7:0] occupancy,
  output logic       lot_full,
  output logic       timeout
);

  localparam int WW = (PAY_WAIT > 1) ? $clog2(PAY_WAIT) : 1;

  gate_state_t   state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          exit_evt;
  logic          gate_open_q, gate_open_d;
  logic          car_exited_q, car_exited_d;
  logic          red_q, red_d, green_q, green_d;
  logic [6:0]    hex_1_q, hex_1_d, hex_2_q, hex_2_d;

`ifdef EXIT_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;
`else
  logic          unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    exit_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sensor_exit_approach && occupancy != 8'd0) state_d = ST_WAIT_PAY;
      end
      ST_WAIT_PAY: begin
        if (wait_q == WW'(PAY_WAIT - 1)) begin
          state_d = code_matches(pay_1, pay_2) ? ST_OPEN : ST_PAY_BAD;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_PAY_BAD: begin
        if (code_matches(pay_1, pay_2)) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        if (sensor_exit_clear) begin
          state_d  = ST_IDLE;
          exit_evt = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef EXIT_TIMEOUT_EN
    // A successful payment on the last allowed cycle wins over the abandon timeout.
    tmo_d     = '0;
    timeout_d = 1'b0;
    if (state_q == ST_WAIT_PAY || state_q == ST_PAY_BAD) begin
      if (state_d != ST_OPEN && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ST_IDLE;
        timeout_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
`endif
  end

  always_comb begin
    gate_open_d  = 1'b0;
    car_exited_d = exit_evt;
    red_d        = 1'b1;
    green_d      = 1'b0;
    hex_1_d      = HEX_BLANK;
    hex_2_d      = HEX_BLANK;
    case (state_q)
      ST_WAIT_PAY: begin
        hex_1_d = HEX_WAIT_1;
        hex_2_d = HEX_WAIT_2;
      end
      ST_PAY_BAD: begin
        red_d   = ~red_q;
        hex_1_d = HEX_BAD_1;
        hex_2_d = HEX_BAD_2;
      end
      ST_OPEN: begin
        gate_open_d = 1'b1;
        red_d       = 1'b0;
        green_d     = ~green_q;
        hex_1_d     = HEX_OPEN_1;
        hex_2_d     = HEX_OPEN_2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      gate_open_q  <= 1'b0;
      car_exited_q <= 1'b0;
      red_q        <= 1'b1;
      green_q      <= 1'b0;
      hex_1_q      <= HEX_BLANK;
      hex_2_q      <= HEX_BLANK;
`ifdef EXIT_TIMEOUT_EN
      tmo_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      gate_open_q  <= gate_open_d;
      car_exited_q <= car_exited_d;
      red_q        <= red_d;
      green_q      <= green_d;
      hex_1_q      <= hex_1_d;
      hex_2_q      <= hex_2_d;
`ifdef EXIT_TIMEOUT_EN
      tmo_q        <= tmo_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  parking_occupancy_counter #(
    .CAPACITY(CAPACITY)
  ) u_occupancy (
    .clk  (clk),
    .reset(reset),
    .inc  (car_entered),
    .dec  (exit_evt),
    .count(occupancy),
    .full (lot_full)
  );

  assign gate_open  = gate_open_q;
  assign car_exited = car_exited_q;
  assign red_led    = red_q;
  assign green_led  = green_q;
  assign hex_1      = hex_1_q;
  assign hex_2      = hex_2_q;
`ifdef EXIT_TIMEOUT_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_parking_exit_gate.sv
// tb/tb_parking_exit_gate.sv - vector table, directed corner sequences and random run vs reference model
module tb_parking_exit_gate;

  localparam int CAP = 15;
  localparam int PW  = 4;
  localparam int TO  = 64;

  logic       clk = 1'b0;
  logic       reset, ce, app, clr;
  logic [1:0] p1, p2;
  logic       gate_open, car_exited, green_led, red_led, lot_full, timeout;
  logic [6:0] hex_1, hex_2;
  logic [7:0] occupancy;

  parking_exit_gate #(.CAPACITY(CAP), .PAY_WAIT(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .car_entered(ce), .sensor_exit_approach(app),
    .sensor_exit_clear(clr), .pay_1(p1), .pay_2(p2), .gate_open(gate_open),
    .car_exited(car_exited), .green_led(green_led), .red_led(red_led),
    .hex_1(hex_1), .hex_2(hex_2), .occupancy(occupancy), .lot_full(lot_full),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_WAIT, M_BAD, M_OPEN} mphase_t;
  mphase_t    m_ph;
  int         m_in_wait, m_in_pending, m_occ;
  bit         e_gate, e_exit, e_red, e_green, e_tmo;
  logic [6:0] e_h1, e_h2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Outputs lag the phase by one edge, so they are derived from the phase held before this edge.
  task automatic model_edge();
    bit      ok;
    mphase_t nx;
    if (!reset) begin
      m_ph = M_IDLE; m_occ = 0; m_in_wait = 0; m_in_pending = 0;
      e_gate = 0; e_exit = 0; e_tmo = 0; e_red = 1; e_green = 0;
      e_h1 = 7'h7F; e_h2 = 7'h7F;
      return;
    end
    ok = (p1 == 2'b10) && (p2 == 2'b01);
    e_gate = (m_ph == M_OPEN);
    e_exit = (m_ph == M_OPEN) && clr;
    e_tmo  = 0;
    case (m_ph)
      M_IDLE:  begin e_red = 1; e_green = 0; e_h1 = 7'h7F; e_h2 = 7'h7F; end
      M_WAIT:  begin e_red = 1; e_green = 0; e_h1 = 7'h06; e_h2 = 7'h2B; end
      M_BAD:   begin e_red = !e_red; e_green = 0; e_h1 = 7'h06; e_h2 = 7'h06; end
      default: begin e_green = !e_green; e_red = 0; e_h1 = 7'h02; e_h2 = 7'h40; end
    endcase
    nx = m_ph;
    case (m_ph)
      M_IDLE: if (app && m_occ > 0) begin nx = M_WAIT; m_in_wait = 0; m_in_pending = 0; end
      M_WAIT: begin m_in_wait++; if (m_in_wait == PW) nx = ok ? M_OPEN : M_BAD; end
      M_BAD:  if (ok) nx = M_OPEN;
      default: if (clr) nx = M_IDLE;
    endcase
    if (m_ph == M_WAIT || m_ph == M_BAD) begin
      m_in_pending++;
`ifdef EXIT_TIMEOUT_EN
      if (nx != M_OPEN && m_in_pending == TO) begin nx = M_IDLE; e_tmo = 1; end
`endif
    end
    if (ce && !e_exit) m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
    else if (e_exit && !ce) m_occ = m_occ - 1;
    m_ph = nx;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gate_open", int'(gate_open), int'(e_gate));
    chk("car_exited", int'(car_exited), int'(e_exit));
    chk("red_led", int'(red_led), int'(e_red));
    chk("green_led", int'(green_led), int'(e_green));
    chk("hex_1", int'(hex_1), int'(e_h1));
    chk("hex_2", int'(hex_2), int'(e_h2));
    chk("occupancy", int'(occupancy), m_occ);
    chk("lot_full", int'(lot_full), int'(m_occ == CAP));
    chk("timeout", int'(timeout), int'(e_tmo));
  endtask

  task automatic do_reset();
    reset = 0; ce = 0; app = 0; clr = 0; p1 = 2'b00; p2 = 2'b00;
    step();
    reset = 1;
  endtask

  task automatic good_code(); p1 = 2'b10; p2 = 2'b01; endtask
  task automatic bad_code();  p1 = 2'b01; p2 = 2'b10; endtask

  typedef struct {
    bit ce; bit app; bit clr; logic [1:0] p1; logic [1:0] p2;
    bit gate; bit exited; int occ;
  } vec_t;
  vec_t tbl[11];

  initial begin
    bit prev_red, seen;
    int n;

    tbl[0]  = '{1, 0, 0, 2'b00, 2'b00, 0, 0, 1};
    tbl[1]  = '{1, 0, 0, 2'b00, 2'b00, 0, 0, 2};
    tbl[2]  = '{1, 0, 0, 2'b00, 2'b00, 0, 0, 3};
    tbl[3]  = '{0, 1, 0, 2'b10, 2'b01, 0, 0, 3};
    tbl[4]  = '{0, 1, 0, 2'b10, 2'b01, 0, 0, 3};
    tbl[5]  = '{0, 1, 0, 2'b10, 2'b01, 0, 0, 3};
    tbl[6]  = '{0, 1, 0, 2'b10, 2'b01, 0, 0, 3};
    tbl[7]  = '{0, 1, 0, 2'b10, 2'b01, 0, 0, 3};
    tbl[8]  = '{0, 0, 0, 2'b10, 2'b01, 1, 0, 3};
    tbl[9]  = '{0, 0, 1, 2'b10, 2'b01, 1, 1, 2};
    tbl[10] = '{0, 0, 0, 2'b00, 2'b00, 0, 0, 2};

    do_reset();
    chk("rst_red", int'(red_led), 1);
    chk("rst_hex_1", int'(hex_1), 7'h7F);
    chk("rst_occ", int'(occupancy), 0);

    for (int i = 0; i < 11; i++) begin
      ce = tbl[i].ce; app = tbl[i].app; clr = tbl[i].clr; p1 = tbl[i].p1; p2 = tbl[i].p2;
      step();
      chk($sformatf("vec%0d_gate", i), int'(gate_open), int'(tbl[i].gate));
      chk($sformatf("vec%0d_exit", i), int'(car_exited), int'(tbl[i].exited));
      chk($sformatf("vec%0d_occ", i), int'(occupancy), tbl[i].occ);
    end

    // Empty lot: approach must be ignored.
    do_reset();
    app = 1; good_code();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("empty_gate", int'(gate_open), 0);
      chk("empty_hex", int'(hex_1), 7'h7F);
    end
    app = 0;

    // Wrong code: PAY_BAD red blink, then fixed code opens.
    do_reset();
    ce = 1; step(); ce = 0;
    app = 1; bad_code();
    for (int i = 0; i < 6; i++) step();
    chk("bad_hex_1", int'(hex_1), 7'h06);
    chk("bad_hex_2", int'(hex_2), 7'h06);
    for (int i = 0; i < 6; i++) begin
      prev_red = red_led;
      step();
      chk("red_toggle", int'(red_led), int'(!prev_red));
    end
    good_code();
    step();
    chk("fix_gate_lag", int'(gate_open), 0);
    step();
    chk("fix_gate_open", int'(gate_open), 1);
    app = 0; clr = 1; step(); clr = 0; step();

    // Saturation and simultaneous entry/exit.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ce = 1; step(); ce = 0; step();
    end
    chk("sat_occ", int'(occupancy), 15);
    chk("sat_full", int'(lot_full), 1);
    app = 1; good_code();
    for (int i = 0; i < 5; i++) step();
    app = 0; step();
    chk("sat_gate", int'(gate_open), 1);
    ce = 1; clr = 1; step(); ce = 0; clr = 0;
    chk("both_exit", int'(car_exited), 1);
    chk("both_occ", int'(occupancy), 15);
    app = 1; for (int i = 0; i < 6; i++) step();
    app = 0; clr = 1; step(); clr = 0;
    chk("dec_occ", int'(occupancy), 14);
    chk("dec_full", int'(lot_full), 0);

    // Abandoned exit with the wrong code held.
    do_reset();
    ce = 1; step(); ce = 0;
    app = 1; bad_code(); step();
    seen = 0; n = 0;
    while (!seen && n < 100) begin
      step(); n++;
      if (timeout) seen = 1;
    end
    app = 0;
`ifdef EXIT_TIMEOUT_EN
    chk("timeout_seen", int'(seen), 1);
    chk("timeout_latency", n, TO);
    chk("timeout_occ", int'(occupancy), 1);
    step(); step();
    chk("timeout_idle_hex", int'(hex_1), 7'h7F);
`else
    chk("no_timeout", int'(seen), 0);
    chk("stuck_hex_1", int'(hex_1), 7'h06);
    chk("stuck_hex_2", int'(hex_2), 7'h06);
`endif

    // Reset while OPEN: no exit pulse, everything cleared.
    do_reset();
    ce = 1; step(); ce = 0;
    app = 1; good_code();
    for (int i = 0; i < 5; i++) step();
    app = 0; step();
    chk("pre_rst_gate", int'(gate_open), 1);
    reset = 0; clr = 1; step();
    chk("rst_open_gate", int'(gate_open), 0);
    chk("rst_open_exit", int'(car_exited), 0);
    chk("rst_open_occ", int'(occupancy), 0);
    chk("rst_open_hex", int'(hex_2), 7'h7F);
    reset = 1; clr = 0; step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ce    = ($urandom % 4) == 0;
      app   = ($urandom % 3) == 0;
      clr   = ($urandom % 4) == 0;
      reset = ($urandom % 97) != 0;
      if ($urandom % 2) good_code();
      else begin p1 = 2'($urandom); p2 = 2'($urandom); end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
